bram_sdp_be: RTL and testbench
==============================

// Module: bram_sdp_be
// PURPOSE
//  Simple-dual-port synchronous block RAM, next generation of the team's BRAM.
//  Adds per-byte write enables, an explicit read enable with rd_valid, 1- or 2-stage read latency,
//  and selectable read-during-write mode.
//  A built-in clear sequencer zeroes the array after reset, so no initial blocks are needed (ASIC/FPGA portable).
//  Used as the storage primitive under FIFOs, descriptor tables and line buffers.
// PARAMETERS
//  DATA_WIDTH      32  word width; must be a multiple of BYTE_WIDTH
//  ADDR_WIDTH      8   address bits; DEPTH = 2**ADDR_WIDTH words
//  BYTE_WIDTH      8   bits per write-enable lane; NB = DATA_WIDTH/BYTE_WIDTH
//  RD_LATENCY      1   1 or 2 clk from rd_en to rd_data/rd_valid; other values are an elaboration error
//  RDW_MODE        0   same-address read+write in one cycle: 0 = old data, 1 = new (merged) data
//  CLEAR_ON_RESET  1   1 = sweep array to 0 after reset; 0 = no sweep, busy tied 0
// PORTS
//  clk       in   1           clock, all logic on rising edge
//  rst       in   1           reset, synchronous, active-high
//  wr_en     in   1           write request
//  wr_addr   in   ADDR_WIDTH  write address
//  wr_data   in   DATA_WIDTH  write data
//  wr_be     in   NB          byte-lane enables; bit i covers wr_data[i*BYTE_WIDTH +: BYTE_WIDTH]
//  rd_en     in   1           read request
//  rd_addr   in   ADDR_WIDTH  read address
//  rd_data   out  DATA_WIDTH  read data, valid when rd_valid=1
//  rd_valid  out  1           one-cycle pulse per accepted read
//  busy      out  1           clear sweep in progress; requests ignored
// BEHAVIOUR
//  - Reset (rst=1 at posedge):
//    - rd_data=0, rd_valid=0, all pipeline stages cleared.
//    - Sequencer to CLEAR with addr counter=0; busy=1 from the first cycle after rst.
//  - Clear sweep, states IDLE and CLEAR:
//    - CLEAR writes 0 (all lanes) to counter address, one word per cycle, DEPTH cycles total.
//    - After address DEPTH-1: -> IDLE, busy=0 on the next cycle. IDLE is terminal until the next rst.
//    - rst during CLEAR restarts the sweep at address 0.
//    - CLEAR_ON_RESET=0: reset goes straight to IDLE, busy never asserts, contents untouched.
//  - While busy=1: wr_en and rd_en are ignored; no rd_valid is produced.
//  - Write (busy=0, wr_en=1):
//    - Lanes with wr_be[i]=1 update at the posedge; other lanes keep their value.
//    - wr_be=0 is a no-op.
//  - Read (busy=0, rd_en=1) at edge N:
//    - rd_data and rd_valid=1 appear after edge N+RD_LATENCY-1, i.e. visible RD_LATENCY cycles later.
//    - Fully pipelined: back-to-back reads give back-to-back rd_valid.
//    - rd_en=0: rd_valid=0 and rd_data holds its last value.
//  - Same-address rd_en+wr_en in one cycle:
//    - RDW_MODE=0: returns pre-write word.
//    - RDW_MODE=1: returns enabled lanes from wr_data, other lanes from the old word.
//  - Different addresses: fully independent. Write at N then read at N+1 returns new data in both modes.
//  - rst mid-read: in-flight reads are dropped; rd_valid is 0 the cycle after rst.
//  - Address arithmetic is unsigned ADDR_WIDTH; no wrap logic needed, all addresses are legal.
// STRUCTURE
//  - Shared package bram_pkg:
//    - localparams RDW_OLD=0, RDW_NEW=1.
//    - Sequencer state typedef {ST_IDLE, ST_CLEAR}.
//  - Sub-module bram_init_seq: holds the clear FSM and counter.
//    - Outputs busy, clr_we, clr_addr.
//    - clr_we/clr_addr are muxed onto the write port ahead of the array.
//  - Array, byte-lane merge, RDW bypass and the RD_LATENCY pipe live in this module.
// TESTING
//  1. Reset, DEPTH=256: busy high exactly 256 cycles. Then read all addresses -> every rd_data=0.
//  2. Write 0xA5A5A5A5 to addr 3, wr_be=4'b0101, over a cleared word.
//     Read addr 3 -> 0x00A500A5 after RD_LATENCY cycles (check both latencies 1 and 2).
//  3. Addr 7 holds 0x11111111.
//     Same-cycle write 0x22222222 (be=4'b1100) + read addr 7 -> RDW_MODE=0: 0x11111111; RDW_MODE=1: 0x22221111.
//  4. 16 back-to-back reads of addrs 0..15 (preloaded data = addr) -> 16 consecutive rd_valid, data 0..15 in order.
//  5. rd_en/wr_en asserted while busy=1 -> no rd_valid and no write. Array still all-zero after sweep.
//  6. rst at cycle 100 of the sweep, with a read in flight -> rd_valid=0, busy stays high 256 more cycles.

Source files
------------

// File: rtl/bram_pkg.sv
// Shared types and constants for the byte-enable simple-dual-port BRAM.
// Imported by the clear sequencer and the RAM top.
package bram_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } seq_state_t;

endpackage

// File: rtl/bram_init_seq.sv
// Post-reset clear sequencer: walks every address once, writing zero.
// Holds busy high for the whole sweep, then idles until the next reset.
module bram_init_seq
  import bram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  seq_state_t            state_q;
  seq_state_t            state_d;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (&cnt_q) state_d = ST_IDLE;
      end
    endcase
  end

  assign busy     = (state_q == ST_CLEAR);
  assign clr_addr = cnt_q;

endmodule

// File: rtl/bram_sdp_be.sv
// Simple-dual-port BRAM with byte enables, read valid, 1/2-cycle read
// latency, selectable read-during-write and a self-clearing array.
module bram_sdp_be
  import bram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int BYTE_WIDTH     = 8,
  parameter int RD_LATENCY     = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
  input  logic                             rd_en,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_valid,
  output logic                             busy
);

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_lat
    $error("bram_sdp_be: RD_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_bw
    $error("bram_sdp_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  bram_init_seq #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_seq (
    .clk     (clk),
    .rst     (rst),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_addr(clr_addr)
  );

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  we;
  logic [ADDR_WIDTH-1:0] wa;
  logic [DATA_WIDTH-1:0] wd;
  logic [NB-1:0]         wb;

  // The sweep owns the write port while busy; user requests are dropped.
  always_comb begin
    we = wr_en;
    wa = wr_addr;
    wd = wr_data;
    wb = wr_be;
    if (busy) begin
      we = clr_we;
      wa = clr_addr;
      wd = '0;
      wb = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (wb[i]) mem[wa][i*BYTE_WIDTH +: BYTE_WIDTH] <= wd[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  logic                  rd_acc;
  logic                  hit;
  logic                  v1_q;
  logic [DATA_WIDTH-1:0] raw_q;
  logic [DATA_WIDTH-1:0] wdq;
  logic [NB-1:0]         mask_q;
  logic [DATA_WIDTH-1:0] s1_data;

  assign rd_acc = rd_en && !busy;
  assign hit    = (RDW_MODE != RDW_OLD) && wr_en && !busy
               && (wr_addr == rd_addr);

  // Raw array word is registered as-is; new-data bypass merges after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      raw_q  <= '0;
      wdq    <= '0;
      mask_q <= '0;
    end else begin
      v1_q <= rd_acc;
      if (rd_acc) begin
        raw_q  <= mem[rd_addr];
        wdq    <= wr_data;
        mask_q <= hit ? wr_be : '0;
      end
    end
  end

  always_comb begin
    s1_data = raw_q;
    for (int i = 0; i < NB; i++) begin
      if (mask_q[i]) s1_data[i*BYTE_WIDTH +: BYTE_WIDTH] = wdq[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  if (RD_LATENCY == 1) begin : g_lat1
    assign rd_data  = s1_data;
    assign rd_valid = v1_q;
  end else begin : g_lat2
    logic                  v2_q;
    logic [DATA_WIDTH-1:0] d2_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        v2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) d2_q <= s1_data;
      end
    end
    assign rd_data  = d2_q;
    assign rd_valid = v2_q;
  end

endmodule

// File: tb/tb_bram_sdp_be.sv
// Bench for bram_sdp_be: two instances (lat1/old-data, lat2/new-data)
// share stimulus and are checked against a queue-based memory model.
module tb_bram_sdp_be;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int NB    = 4;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [NB-1:0] wr_be;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] d0, d1;
  logic          v0, v1, b0, b1;

  always #5 clk = ~clk;

  bram_sdp_be #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8),
    .RD_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)
  ) u0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(d0), .rd_valid(v0), .busy(b0)
  );

  bram_sdp_be #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8),
    .RD_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)
  ) u1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(d1), .rd_valid(v1), .busy(b1)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } rd_t;

  rd_t           q0[$];
  rd_t           q1[$];
  logic [DW-1:0] mem_m [DEPTH];
  int            clr_left = 0;
  int            cyc = 0;
  logic          ev0 = 1'b0, ev1 = 1'b0;
  logic [DW-1:0] ed0 = '0, ed1 = '0;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                          input logic [DW-1:0] nw,
                                          input logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < NB; i++)
      if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  // One clock: model advances at the edge, DUTs checked at the negedge.
  task automatic tick();
    logic [DW-1:0] old, nw;
    @(posedge clk);
    cyc++;
    if (rst) begin
      clr_left = DEPTH;
      q0.delete();
      q1.delete();
      ed0 = '0;
      ed1 = '0;
    end else if (clr_left > 0) begin
      mem_m[DEPTH - clr_left] = '0;
      clr_left--;
    end else begin
      if (rd_en) begin
        old = mem_m[rd_addr];
        nw  = (wr_en && wr_addr == rd_addr) ? merge(old, wr_data, wr_be) : old;
        q0.push_back('{cyc, old});
        q1.push_back('{cyc + 1, nw});
      end
      if (wr_en) mem_m[wr_addr] = merge(mem_m[wr_addr], wr_data, wr_be);
    end
    ev0 = 1'b0;
    if (q0.size() > 0 && q0[0].due == cyc) begin
      ev0 = 1'b1;
      ed0 = q0[0].d;
      void'(q0.pop_front());
    end
    ev1 = 1'b0;
    if (q1.size() > 0 && q1[0].due == cyc) begin
      ev1 = 1'b1;
      ed1 = q1[0].d;
      void'(q1.pop_front());
    end
    @(negedge clk);
    chk("busy0", b0, (clr_left > 0));
    chk("busy1", b1, (clr_left > 0));
    chk("valid0", v0, ev0);
    chk("valid1", v1, ev1);
    chk("data0", d0, ed0);
    chk("data1", d1, ed1);
  endtask

  task automatic idle();
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  typedef struct {
    bit            we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [NB-1:0] be;
    bit            re;
    logic [AW-1:0] ra;
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
  } vec_t;

  vec_t vt[$];
  int   n, c0, c1;

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; wr_data = '0; wr_be = '0; rd_addr = '0;
    tick();

    // Sweep with requests hammering already-cleared addresses.
    n = 0;
    while (b0 && n < 400) begin
      n++;
      if (n > 20) begin
        rst = 1'b0;
        wr_en = 1'b1; wr_addr = AW'($urandom_range(0, 15));
        wr_data = $urandom; wr_be = '1;
        rd_en = 1'b1; rd_addr = AW'($urandom_range(0, 255));
      end else idle();
      tick();
    end
    idle();
    chk("busy_len", n, 256);

    c0 = 0; c1 = 0;
    for (int a = 0; a < DEPTH; a++) begin
      rd_en = 1'b1; rd_addr = AW'(a);
      tick();
      c0 += int'(v0); c1 += int'(v1);
    end
    idle();
    tick(); c1 += int'(v1);
    tick();
    chk("zero_rd_cnt0", c0, 256);
    chk("zero_rd_cnt1", c1, 256);

    vt.push_back('{1, 3, 32'hA5A5A5A5, 4'b0101, 0, 0, 0, 0});
    vt.push_back('{0, 0, 0, 0, 1, 3, 32'h00A500A5, 32'h00A500A5});
    vt.push_back('{1, 7, 32'h11111111, 4'b1111, 0, 0, 0, 0});
    vt.push_back('{1, 7, 32'h22222222, 4'b1100, 1, 7, 32'h11111111, 32'h22221111});
    vt.push_back('{0, 0, 0, 0, 1, 7, 32'h22221111, 32'h22221111});
    vt.push_back('{1, 9, 32'hDEADBEEF, 4'b0000, 1, 9, 32'h0, 32'h0});
    vt.push_back('{0, 0, 0, 0, 1, 9, 32'h0, 32'h0});
    vt.push_back('{1, 255, 32'hFFFFFFFF, 4'b1000, 0, 0, 0, 0});
    vt.push_back('{0, 0, 0, 0, 1, 255, 32'hFF000000, 32'hFF000000});
    vt.push_back('{1, 10, 32'h12345678, 4'b1111, 1, 3, 32'h00A500A5, 32'h00A500A5});
    vt.push_back('{0, 0, 0, 0, 1, 10, 32'h12345678, 32'h12345678});
    foreach (vt[i]) begin
      rst = 1'b0;
      wr_en = vt[i].we; wr_addr = vt[i].wa; wr_data = vt[i].wd; wr_be = vt[i].be;
      rd_en = vt[i].re; rd_addr = vt[i].ra;
      tick();
      idle();
      if (vt[i].re) begin
        chk($sformatf("vec%0d_v0", i), v0, 1'b1);
        chk($sformatf("vec%0d_d0", i), d0, vt[i].e0);
      end
      tick();
      if (vt[i].re) begin
        chk($sformatf("vec%0d_v1", i), v1, 1'b1);
        chk($sformatf("vec%0d_d1", i), d1, vt[i].e1);
      end
    end

    for (int a = 0; a < 16; a++) begin
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = DW'(a); wr_be = '1;
      tick();
    end
    idle();
    c0 = 0; c1 = 0;
    for (int a = 0; a < 16; a++) begin
      rd_en = 1'b1; rd_addr = AW'(a);
      tick();
      c0 += int'(v0); c1 += int'(v1);
    end
    idle();
    tick(); c1 += int'(v1);
    chk("b2b_cnt0", c0, 16);
    chk("b2b_cnt1", c1, 16);

    for (int k = 0; k < 1500; k++) begin
      wr_en = 1'($urandom); wr_addr = AW'($urandom_range(0, 7));
      wr_data = $urandom; wr_be = NB'($urandom);
      rd_en = 1'($urandom); rd_addr = AW'($urandom_range(0, 7));
      tick();
    end
    idle();
    tick();

    // Reset with a read in flight in the 2-cycle instance.
    rd_en = 1'b1; rd_addr = 8'd3;
    tick();
    idle(); rst = 1'b1;
    tick();
    idle();
    chk("inflight_v1", v1, 1'b0);
    chk("inflight_v0", v0, 1'b0);

    for (int k = 0; k < 100; k++) tick();
    rst = 1'b1;
    tick();
    idle();
    n = 0;
    while (b0 && n < 400) begin
      n++;
      tick();
    end
    chk("busy_len_restart", n, 256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
